idft_frame_ctrl: RTL

Frame sequencer for the streaming 4-sample/cycle IDFT core. It holds one input frame in a local buffer, issues the core's start pulse, streams the beats, waits for the core's output-start pulse, and captures the result frame into an output buffer for the host. Starts are gated by the LLKI key-loaded status, so an un-keyed core is never run. It sits between the host register shim and the LLKI-wrapped IDFT core.

---
 rtl/idft_frame_ctrl_if.sv | 26 ++
 rtl/idft_frame_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/idft_frame_ctrl_if.sv
// Host-side bus of the IDFT frame sequencer: frame start, input-buffer
// write port, output-buffer read port and status flags.
// The host drives the master modport; idft_frame_ctrl uses the slave modport.
interface idft_frame_ctrl_if #(
  parameter int AW = 3
);
  logic          start;
  logic          in_we;
  logic [AW-1:0] in_addr;
  logic [63:0]   in_data;
  logic [AW-1:0] out_addr;
  logic [63:0]   out_data;
  logic          busy;
  logic          done;
  logic          error;

  modport master (
    output start, in_we, in_addr, in_data, out_addr,
    input  out_data, busy, done, error
  );

  modport slave (
    input  start, in_we, in_addr, in_data, out_addr,
    output out_data, busy, done, error
  );
endinterface

// File: rtl/idft_frame_ctrl.sv
// Frame sequencer for the streaming 4-sample/cycle IDFT core.
// The sequencer holds one input frame, pulses the core start, streams
// BEATS beats, waits for the core output-start pulse and captures the
// result frame into an output buffer that the host reads.
// A frame only starts while the LLKI key is loaded.
// Optional feature macro: IDFT_CTRL_PERF_EN adds the lat_cyc output, which
// holds the core latency (core_next to core_next_out) of the last frame.
module idft_frame_ctrl #(
  parameter int N_POINTS    = 32,
  parameter int TIMEOUT_CYC = 1024,
  parameter int AW          = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          key_loaded,
  idft_frame_ctrl_if.slave host,
  output logic          core_next,
  output logic [63:0]   core_x,
  input  logic          core_next_out,
  input  logic [63:0]   core_y
`ifdef IDFT_CTRL_PERF_EN
  ,
  output logic [15:0]   lat_cyc
`endif
);

  localparam int BEATS = N_POINTS / 4;
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  localparam logic [AW-1:0] LAST_BEAT = AW'(BEATS - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_STREAM,
    S_WAIT_OUT,
    S_CAPTURE,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [63:0]   in_buf  [BEATS];
  logic [63:0]   out_buf [BEATS];

  logic [AW-1:0] beat;
  logic [AW-1:0] cap;
  logic          cap_run;
  logic [TW-1:0] tmo;
  logic [63:0]   out_q;

  logic          quiet;
  logic          go;
  logic          cap_start;

  // States in which the host owns the input buffer and may launch a frame.
  assign quiet = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
  assign go    = host.start && key_loaded;

  // Capture locks onto the first output-start pulse seen once the core
  // has been started, even if the core answers before streaming ends.
  assign cap_start = core_next_out && !cap_run &&
                     ((state == S_STREAM) || (state == S_WAIT_OUT));

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values and ordering between always_ff blocks cannot matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (go) begin
          state_nxt = S_ARM;
        end else if (host.start && (state != S_ERR)) begin
          // An un-keyed start is reported, never run.
          state_nxt = S_ERR;
        end
      end
      S_ARM: begin
        state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (beat == LAST_BEAT) begin
          state_nxt = (cap_run || cap_start) ? S_CAPTURE : S_WAIT_OUT;
        end
      end
      S_WAIT_OUT: begin
        if (core_next_out) begin
          state_nxt = S_CAPTURE;
        end else if (tmo == TMO_LAST) begin
          state_nxt = S_ERR;
        end
      end
      S_CAPTURE: begin
        if (!cap_run || (cap == LAST_BEAT)) begin
          state_nxt = S_DONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Stream beat counter and WAIT_OUT timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat <= '0;
      tmo  <= '0;
    end else begin
      if (state == S_ARM) begin
        beat <= '0;
      end else if (state == S_STREAM) begin
        beat <= beat + AW'(1);
      end
      if (state == S_WAIT_OUT) begin
        tmo <= tmo + TW'(1);
      end else begin
        tmo <= '0;
      end
    end
  end

  // Capture counter, run independently of the stream counter so that an
  // early core answer overlaps streaming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap     <= '0;
      cap_run <= 1'b0;
    end else if (cap_start) begin
      cap     <= '0;
      cap_run <= 1'b1;
    end else if (cap_run) begin
      cap <= cap + AW'(1);
      if (cap == LAST_BEAT) begin
        cap_run <= 1'b0;
      end
    end
  end

  // Input buffer write port; frozen while a frame is in flight.
  // NOTE: the frame buffers carry no reset: their contents are undefined
  // after reset and clearing them would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (host.in_we && quiet) begin
      in_buf[host.in_addr] <= host.in_data;
    end
  end

  // Output buffer write port, one core beat per capture cycle.
  always_ff @(posedge clk) begin
    if (cap_run) begin
      out_buf[cap] <= core_y;
    end
  end

  // Registered host read of the output buffer (old data until overwritten).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_buf[host.out_addr];
    end
  end

`ifdef IDFT_CTRL_PERF_EN
  logic [15:0] lat_cnt;
  logic [15:0] lat_q;

  // Core latency: cycles from the core_next pulse to core_next_out,
  // saturating; latched when capture begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt <= '0;
      lat_q   <= '0;
    end else begin
      if (state == S_ARM) begin
        lat_cnt <= 16'd1;
      end else if (((state == S_STREAM) || (state == S_WAIT_OUT)) &&
                   (lat_cnt != 16'hFFFF)) begin
        lat_cnt <= lat_cnt + 16'd1;
      end
      if (cap_start) begin
        lat_q <= lat_cnt;
      end
    end
  end

  assign lat_cyc = lat_q;
`endif

  assign core_next     = (state == S_ARM);
  assign core_x        = (state == S_STREAM) ? in_buf[beat] : '0;
  assign host.busy     = !quiet;
  assign host.done     = (state == S_DONE);
  assign host.error    = (state == S_ERR);
  assign host.out_data = out_q;

endmodule
